// File: rtl/dep_rule_cmd_seq_pkg.sv
// Shared deparser definitions: command header layout, magic value and the
// command-sequencer state type.
package dep_rule_cmd_seq_pkg;

  localparam logic [7:0] CMD_MAGIC      = 8'hA5;
  localparam int         CMD_ADDR_WIDTH = 11;

  // Header word field positions
  localparam int HDR_MAGIC_MSB = 31;
  localparam int HDR_MAGIC_LSB = 24;
  localparam int HDR_CNT_MSB   = 23;
  localparam int HDR_CNT_LSB   = 16;
  localparam int HDR_BASE_MSB  = CMD_ADDR_WIDTH - 1;
  localparam int HDR_BASE_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_GAP  = 2'd2,
    ST_DROP = 2'd3
  } state_t;

endpackage

// File: rtl/dep_rule_cmd_seq.sv
// Command packet to rule-register write sequencer with framing checks and
// good-packet / error counters. Error counter present only with DEP_RULE_CMD_ERR_CNT_EN.
module dep_rule_cmd_seq
  import dep_rule_cmd_seq_pkg::*;
#(
  parameter int WR_GAP = 0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_cmd_valid,
  input  logic [31:0] i_cmd_data,
  input  logic        i_cmd_last,
  output logic        o_cmd_ready,
  output logic        o_rule_wren,
  output logic [31:0] o_rule_wdata,
  output logic [31:0] o_rule_addr,
  output logic [15:0] o_pkt_cnt,
  output logic [15:0] o_err_cnt
);

  localparam logic [3:0] GAP_LOAD = (WR_GAP > 0) ? 4'(WR_GAP - 1) : 4'd0;

  state_t                    state_reg, state_next;
  state_t                    pend_reg, pend_next;
  state_t                    data_tgt;
  logic [CMD_ADDR_WIDTH-1:0] base_reg, base_next;
  logic [7:0]                cnt_reg, cnt_next;
  logic [7:0]                idx_reg, idx_next;
  logic [7:0]                idx_inc;
  logic [3:0]                gap_reg, gap_next;
  logic                      ready_reg;
  logic                      wren_reg, wren_next;
  logic [31:0]               wdata_reg, wdata_next;
  logic [CMD_ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [15:0]               pkt_cnt_reg;
  logic                      pkt_inc;
  logic                      accept;
  logic                      hdr_ok;
  logic                      data_done;
  logic [7:0]                hdr_magic;
  logic [7:0]                hdr_cnt;

  assign accept    = i_cmd_valid & ready_reg;
  assign hdr_magic = i_cmd_data[HDR_MAGIC_MSB:HDR_MAGIC_LSB];
  assign hdr_cnt   = i_cmd_data[HDR_CNT_MSB:HDR_CNT_LSB];
  assign hdr_ok    = (hdr_magic == CMD_MAGIC) && (hdr_cnt != 8'd0);
  assign idx_inc   = idx_reg + 8'd1;
  assign data_done = (idx_inc == cnt_reg);

  // Where a data word leads once its write is issued (before any GAP)
  always_comb begin
    data_tgt = ST_DATA;
    if (i_cmd_last) begin
      data_tgt = ST_IDLE;
    end else if (data_done) begin
      data_tgt = ST_DROP;
    end
  end

  always_comb begin
    state_next = state_reg;
    pend_next  = pend_reg;
    base_next  = base_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    gap_next   = gap_reg;
    wren_next  = 1'b0;
    wdata_next = wdata_reg;
    addr_next  = addr_reg;
    pkt_inc    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (hdr_ok && !i_cmd_last) begin
            base_next  = i_cmd_data[HDR_BASE_MSB:HDR_BASE_LSB];
            cnt_next   = hdr_cnt;
            idx_next   = 8'd0;
            state_next = ST_DATA;
          end else if (!i_cmd_last) begin
            state_next = ST_DROP;
          end
        end
      end
      ST_DATA: begin
        if (accept) begin
          wren_next  = 1'b1;
          wdata_next = i_cmd_data;
          addr_next  = base_reg + {3'b000, idx_reg};
          idx_next   = idx_inc;
          pkt_inc    = data_done && i_cmd_last;
          if (WR_GAP > 0) begin
            state_next = ST_GAP;
            pend_next  = data_tgt;
            gap_next   = GAP_LOAD;
          end else begin
            state_next = data_tgt;
          end
        end
      end
      ST_GAP: begin
        if (gap_reg == 4'd0) begin
          state_next = pend_reg;
        end else begin
          gap_next = gap_reg - 4'd1;
        end
      end
      ST_DROP: begin
        if (accept && i_cmd_last) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg   <= ST_IDLE;
      pend_reg    <= ST_IDLE;
      base_reg    <= '0;
      cnt_reg     <= '0;
      idx_reg     <= '0;
      gap_reg     <= '0;
      ready_reg   <= 1'b0;
      wren_reg    <= 1'b0;
      wdata_reg   <= '0;
      addr_reg    <= '0;
      pkt_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      pend_reg    <= pend_next;
      base_reg    <= base_next;
      cnt_reg     <= cnt_next;
      idx_reg     <= idx_next;
      gap_reg     <= gap_next;
      ready_reg   <= (state_next != ST_GAP);
      wren_reg    <= wren_next;
      wdata_reg   <= wdata_next;
      addr_reg    <= addr_next;
      pkt_cnt_reg <= pkt_cnt_reg + {15'd0, pkt_inc};
    end
  end

`ifdef DEP_RULE_CMD_ERR_CNT_EN
  logic        err_inc;
  logic [15:0] err_cnt_reg;

  always_comb begin
    err_inc = 1'b0;
    if (accept) begin
      case (state_reg)
        ST_IDLE: err_inc = !(hdr_ok && !i_cmd_last);
        ST_DATA: err_inc = data_done ^ i_cmd_last;
        default: err_inc = 1'b0;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_cnt_reg <= '0;
    end else if (err_inc && (err_cnt_reg != 16'hFFFF)) begin
      err_cnt_reg <= err_cnt_reg + 16'd1;
    end
  end

  assign o_err_cnt = err_cnt_reg;
`else
  assign o_err_cnt = 16'd0;
`endif

  assign o_cmd_ready  = ready_reg;
  assign o_rule_wren  = wren_reg;
  assign o_rule_wdata = wdata_reg;
  assign o_rule_addr  = {{(32 - CMD_ADDR_WIDTH){1'b0}}, addr_reg};
  assign o_pkt_cnt    = pkt_cnt_reg;

endmodule

// File: tb/tb_dep_rule_cmd_seq.sv
// Scoreboard bench for dep_rule_cmd_seq: one instance with WR_GAP=0, one with WR_GAP=2.
module tb_dep_rule_cmd_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid [2];
  logic [31:0] cmd_data  [2];
  logic        cmd_last  [2];
  logic        ready     [2];
  logic        wren      [2];
  logic [31:0] wdata     [2];
  logic [31:0] addr      [2];
  logic [15:0] pkt       [2];
  logic [15:0] err       [2];

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    int          dut;
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dep_rule_cmd_seq #(.WR_GAP(0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cmd_valid(cmd_valid[0]), .i_cmd_data(cmd_data[0]), .i_cmd_last(cmd_last[0]),
    .o_cmd_ready(ready[0]), .o_rule_wren(wren[0]), .o_rule_wdata(wdata[0]),
    .o_rule_addr(addr[0]), .o_pkt_cnt(pkt[0]), .o_err_cnt(err[0])
  );

  dep_rule_cmd_seq #(.WR_GAP(2)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cmd_valid(cmd_valid[1]), .i_cmd_data(cmd_data[1]), .i_cmd_last(cmd_last[1]),
    .o_cmd_ready(ready[1]), .o_rule_wren(wren[1]), .o_rule_wdata(wdata[1]),
    .o_rule_addr(addr[1]), .o_pkt_cnt(pkt[1]), .o_err_cnt(err[1])
  );

  function automatic logic [31:0] ee(input int n);
`ifdef DEP_RULE_CMD_ERR_CNT_EN
    return 32'(n);
`else
    return 32'd0 & 32'(n);
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (wren[d] === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write dut%0d: addr %h data %h, none expected", d, addr[d], wdata[d]);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.dut != d || e.addr !== addr[d] || e.data !== wdata[d] || cyc != e.cyc + 1) begin
            errors++;
            $display("FAIL write dut%0d: got addr %h data %h cyc %0d, expected dut%0d addr %h data %h cyc %0d",
                     d, addr[d], wdata[d], cyc, e.dut, e.addr, e.data, e.cyc + 1);
          end else begin
            $display("ok   write dut%0d: addr %h data %h", d, addr[d], wdata[d]);
          end
        end
      end
    end
  end

  task automatic send(input int d, input logic [31:0] w, input logic l,
                      input logic wr, input logic [31:0] a, output int waits);
    exp_t e;
    @(negedge clk);
    cmd_valid[d] = 1'b1;
    cmd_data[d]  = w;
    cmd_last[d]  = l;
    waits = 0;
    while (ready[d] !== 1'b1 && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (ready[d] !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout dut%0d: word %h not accepted, ready %b required 1", d, w, ready[d]);
      cmd_valid[d] = 1'b0;
      return;
    end
    if (wr) begin
      e.dut = d; e.addr = a; e.data = w; e.cyc = cyc;
      exp_q.push_back(e);
    end
    @(posedge clk);
  endtask

  // WR_GAP=0 instance must never stall the source
  task automatic s0(input logic [31:0] w, input logic l, input logic wr, input logic [31:0] a);
    int waits;
    send(0, w, l, wr, a, waits);
    chk($sformatf("stall_free %h", w), 32'(waits), 32'd0);
  endtask

  task automatic s1(input logic [31:0] w, input logic l, input logic wr,
                    input logic [31:0] a, input int exp_waits);
    int waits;
    send(1, w, l, wr, a, waits);
    chk($sformatf("gap_ready_low %h", w), 32'(waits), 32'(exp_waits));
  endtask

  task automatic idle(input int d);
    @(negedge clk);
    cmd_valid[d] = 1'b0;
    cmd_last[d]  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      cmd_valid[d] = 1'b0; cmd_data[d] = '0; cmd_last[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready[0]), 32'd0);
    chk("rst_wren",  32'(wren[0]),  32'd0);
    chk("rst_wdata", wdata[0], 32'd0);
    chk("rst_addr",  addr[0],  32'd0);
    chk("rst_pkt",   32'(pkt[0]), 32'd0);
    chk("rst_err",   32'(err[0]), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(ready[0]), 32'd1);

    // Basic 3-word packet
    s0(32'hA503_0100, 1'b0, 1'b0, 0);
    s0(32'h0000_0011, 1'b0, 1'b1, 32'h100);
    s0(32'h0000_0022, 1'b0, 1'b1, 32'h101);
    s0(32'h0000_0033, 1'b1, 1'b1, 32'h102);
    idle(0);
    chk("pkt_basic", 32'(pkt[0]), 32'd1);
    chk("err_basic", 32'(err[0]), ee(0));

    // Address wrap 0x7FF -> 0x000
    s0(32'hA502_07FF, 1'b0, 1'b0, 0);
    s0(32'hAAAA_0001, 1'b0, 1'b1, 32'h7FF);
    s0(32'hAAAA_0002, 1'b1, 1'b1, 32'h000);
    idle(0);
    chk("pkt_wrap", 32'(pkt[0]), 32'd2);
    chk("err_wrap", 32'(err[0]), ee(0));

    // Bad magic, rest of packet dropped
    s0(32'h5A01_0000, 1'b0, 1'b0, 0);
    s0(32'h0000_0001, 1'b0, 1'b0, 0);
    s0(32'h0000_0002, 1'b1, 1'b0, 0);
    idle(0);
    chk("pkt_badmagic", 32'(pkt[0]), 32'd2);
    chk("err_badmagic", 32'(err[0]), ee(1));

    // Short packet: N=3, last on second data word
    s0(32'hA503_0200, 1'b0, 1'b0, 0);
    s0(32'h0000_0001, 1'b0, 1'b1, 32'h200);
    s0(32'h0000_0002, 1'b1, 1'b1, 32'h201);
    idle(0);
    chk("err_short", 32'(err[0]), ee(2));

    // Long packet: N=1 with 3 data words, extras dropped
    s0(32'hA501_0300, 1'b0, 1'b0, 0);
    s0(32'h0000_0003, 1'b0, 1'b1, 32'h300);
    s0(32'h0000_0004, 1'b0, 1'b0, 0);
    s0(32'h0000_0005, 1'b1, 1'b0, 0);
    idle(0);
    chk("err_long", 32'(err[0]), ee(3));
    chk("pkt_long", 32'(pkt[0]), 32'd2);

    // N=0 header, then header-only packet, then a good packet
    s0(32'hA500_0000, 1'b0, 1'b0, 0);
    s0(32'h0000_0009, 1'b1, 1'b0, 0);
    s0(32'hA501_0000, 1'b1, 1'b0, 0);
    s0(32'hA501_0400, 1'b0, 1'b0, 0);
    s0(32'h0000_0077, 1'b1, 1'b1, 32'h400);
    idle(0);
    chk("err_n0_hdronly", 32'(err[0]), ee(5));
    chk("pkt_after_errs", 32'(pkt[0]), 32'd3);

    // WR_GAP=2: two ready-low cycles after every write
    s1(32'hA503_0040, 1'b0, 1'b0, 0, 0);
    s1(32'h0000_00B1, 1'b0, 1'b1, 32'h040, 0);
    s1(32'h0000_00B2, 1'b0, 1'b1, 32'h041, 2);
    s1(32'h0000_00B3, 1'b1, 1'b1, 32'h042, 2);
    s1(32'hA501_0050, 1'b0, 1'b0, 0, 2);
    s1(32'h0000_00C1, 1'b1, 1'b1, 32'h050, 0);
    idle(1);
    chk("gap_pkt", 32'(pkt[1]), 32'd2);
    chk("gap_err", 32'(err[1]), ee(0));

    // Reset during DATA after the first write
    s0(32'hA503_0010, 1'b0, 1'b0, 0);
    s0(32'h0000_00AA, 1'b0, 1'b1, 32'h010);
    idle(0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(ready[0]), 32'd0);
    chk("midrst_wren",  32'(wren[0]),  32'd0);
    chk("midrst_wdata", wdata[0], 32'd0);
    chk("midrst_addr",  addr[0],  32'd0);
    chk("midrst_pkt",   32'(pkt[0]), 32'd0);
    chk("midrst_err",   32'(err[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready_rel", 32'(ready[0]), 32'd1);
    s0(32'hA501_0020, 1'b0, 1'b0, 0);
    s0(32'h0000_0055, 1'b1, 1'b1, 32'h020);
    idle(0);
    chk("post_rst_pkt", 32'(pkt[0]), 32'd1);
    chk("post_rst_err", 32'(err[0]), ee(0));

    repeat (4) @(negedge clk);
    chk("writes_outstanding", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dep_rule_cmd_seq.md
# dep_rule_cmd_seq

Upstream feeder for the deparser rule-configuration stage. Accepts configuration command packets as a 32-bit valid/ready word stream, checks framing, and replays the payload as single-cycle 32-bit register writes (`o_rule_wren` / `o_rule_wdata` / `o_rule_addr`) with an auto-incrementing address. These are the exact write signals the deparser rule-config stage consumes. It also counts good packets and framing errors for software visibility.

## Interface
- `WR_GAP`, default 0: idle cycles forced after every emitted write (0..15). Gives downstream rule tables settling time.
- `i_clk`  in  1  clock
- `i_rst_n`  in  1  reset, asynchronous, active-low
- `i_cmd_valid`  in  1  command word valid
- `i_cmd_data`  in  32  command word
- `i_cmd_last`  in  1  last word of command packet
- `o_cmd_ready`  out  1  word accepted when valid & ready
- `o_rule_wren`  out  1  one-cycle write strobe
- `o_rule_wdata`  out  32  write data
- `o_rule_addr`  out  32  write address; [31:11] always 0
- `o_pkt_cnt`  out  16  packets completed without error; wraps
- `o_err_cnt`  out  16  framing errors; saturates at 0xFFFF

## Operation
- Packet format:
  - Word 0 is the header: [31:24] magic 0xA5, [23:16] N = data word count, [10:0] base address.
  - Words 1..N are data words.
  - Data word k (k = 0..N-1) is written to address (base + k) mod 2048.
- FSM states: IDLE, DATA, GAP, DROP.
- IDLE (ready=1), on an accepted word:
  - Magic ok, N≥1, last=0: latch base and N, clear index, go to DATA.
  - Magic bad or N=0: err+1. If last=1 stay in IDLE, otherwise go to DROP.
  - Magic ok, N≥1, last=1 (header only): err+1, stay in IDLE.
- DATA (ready=1), on an accepted word:
  - Issue a write: wdata = word, addr = base+index. Index +1.
  - Next state:
    - index reaches N with last=1: pkt+1, then IDLE (or GAP).
    - index reaches N with last=0: err+1, go to DROP after any GAP.
    - index < N with last=1: the write still issues; err+1, then IDLE (or GAP).
    - Otherwise stay in DATA (or GAP).
- GAP (ready=0): entered after each write when `WR_GAP`>0. Lasts exactly `WR_GAP` cycles, then returns to the pending state (DATA, IDLE or DROP).
- DROP (ready=1): discards words. Goes to IDLE when an accepted word has last=1.
- Address increment wraps within 11 bits: 0x7FF → 0x000, with no error.
- Counter updates:
  - pkt and err increment on the cycle after the deciding word.
  - Both never change in the same cycle, since one packet yields at most one event.
- Reset mid-packet: the state returns to IDLE and the partial packet is lost. Writes already issued are not undone.

## Timing
- Reset values:
  - `o_cmd_ready` = 0 during reset, 1 in the first cycle after release (IDLE).
  - `o_rule_wren` = 0, `o_rule_wdata` = 0, `o_rule_addr` = 0.
  - `o_pkt_cnt` = 0, `o_err_cnt` = 0.
- Write latency: `o_rule_wren` is high exactly 1 cycle after the data word is accepted. Data and address are registered and stable in that same cycle.
- `o_rule_wdata` and `o_rule_addr` hold their last values when wren=0.
- `o_cmd_ready` is a registered output derived from the state. It does not depend on `i_cmd_valid` in the same cycle.
- Throughput:
  - `WR_GAP`=0: one write per cycle, back-to-back packets with no bubble; the header costs 1 cycle.
  - `WR_GAP`=G: one write per G+1 cycles.
- The source may hold valid without ready; the word and last must then stay stable.

## Configuration
- `DEP_RULE_CMD_ERR_CNT_EN` defined: `o_err_cnt` counts as specified.
- Undefined: the `o_err_cnt` register is removed and the output is tied to 0. The FSM, including DROP and all error transitions, is unchanged.

## Structure
- Shared deparser package holds:
  - constants `CMD_MAGIC` = 8'hA5 and `CMD_ADDR_WIDTH` = 11;
  - the header field positions;
  - the state enum type.
- A single flat module. No sub-module is warranted; the GAP counter is inline.

## Test plan
- Header 0xA5030100 followed by data 0x11, 0x22, 0x33 (last on 0x33): three wren pulses at addr 0x100, 0x101, 0x102 with data 0x11, 0x22, 0x33, each 1 cycle after acceptance; pkt_cnt=1, err_cnt=0.
- Header 0xA50207FF, 2 data words: addresses 0x7FF then 0x000; pkt_cnt=1.
- Bad magic 0x5A010000 then 2 words with last on the second: no wren, err_cnt=1, ready stays 1, back to IDLE.
- Header with N=3 but last on the 2nd data word: 2 writes, err_cnt=1. Header with N=1 followed by 3 data words: 1 write, err_cnt=1, the remaining words dropped.
- `WR_GAP`=2 with a 3-word packet: ready low for exactly 2 cycles after each accept; wren spacing 3 cycles.
- Assert reset during DATA after the 1st write: outputs return to reset values and the next header is accepted normally. Rerun the bad-magic case with `DEP_RULE_CMD_ERR_CNT_EN` undefined: err_cnt=0, FSM behaviour identical.
